// File: rtl/vm_pkg.sv
// Shared definitions for the coin acceptor and vending machine.
// Holds the coin codes on the acceptor-to-machine link and the acceptor state encoding.
package vm_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_ONE  = 2'b01;
    localparam logic [1:0] COIN_TWO  = 2'b10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;
    localparam logic [1:0] ST_JAM     = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous slot sensor line.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: measures sensor pulse width and emits a one-cycle coin code or reject.
// Ports: clk, rst (sync, active-high), coin_sense (async), accept_en, coin[1:0], reject, jam, busy.
module coin_acceptor
    import vm_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int ONE_MIN   = 4,
    parameter int ONE_MAX   = 7,
    parameter int TWO_MIN   = 10,
    parameter int TWO_MAX   = 14,
    parameter int JAM_LIMIT = 200,
    parameter int HOLDOFF   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_sense,
    input  logic       accept_en,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] ONE_LO    = CNT_W'(ONE_MIN);
    localparam logic [CNT_W-1:0] ONE_HI    = CNT_W'(ONE_MAX);
    localparam logic [CNT_W-1:0] TWO_LO    = CNT_W'(TWO_MIN);
    localparam logic [CNT_W-1:0] TWO_HI    = CNT_W'(TWO_MAX);
    localparam logic [CNT_W-1:0] JAM_AT    = CNT_W'(JAM_LIMIT);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF - 1);

    logic             sense_s;
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             in_one;
    logic             in_two;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (coin_sense),
        .q   (sense_s)
    );

    // cnt doubles as pulse length in MEASURE/JAM and dead-time count in HOLDOFF
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign in_one  = (cnt >= ONE_LO) && (cnt <= ONE_HI);
    assign in_two  = (cnt >= TWO_LO) && (cnt <= TWO_HI);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            coin   <= COIN_NONE;
            reject <= 1'b0;
        end else begin
            coin   <= COIN_NONE;
            reject <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (sense_s) begin
                        state <= ST_MEASURE;
                        cnt   <= CNT_W'(1);
                    end
                end
                ST_MEASURE: begin
                    if (sense_s) begin
                        cnt <= cnt_inc;
                        if (cnt_inc == JAM_AT) state <= ST_JAM;
                    end else begin
                        // falling edge seen: cnt holds the full length
                        state <= ST_HOLDOFF;
                        cnt   <= '0;
                        if (accept_en && in_one)
                            coin <= COIN_ONE;
                        else if (accept_en && in_two)
                            coin <= COIN_TWO;
                        else
                            reject <= 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                ST_JAM: begin
                    if (!sense_s) begin
                        state  <= ST_HOLDOFF;
                        cnt    <= '0;
                        reject <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign jam  = (state == ST_JAM);
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// Testbench for coin_acceptor: directed plus randomized pulses against a cycle reference model.
// Drives coin_sense/accept_en/rst, checks coin/reject/jam/busy every cycle.
module tb_coin_acceptor;

    localparam int ONE_MIN   = 4;
    localparam int ONE_MAX   = 7;
    localparam int TWO_MIN   = 10;
    localparam int TWO_MAX   = 14;
    localparam int JAM_LIMIT = 200;
    localparam int HOLDOFF   = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_sense = 1'b0;
    logic       accept_en = 1'b1;
    logic [1:0] coin;
    logic       reject;
    logic       jam;
    logic       busy;

    always #5 clk = ~clk;

    coin_acceptor dut (
        .clk        (clk),
        .rst        (rst),
        .coin_sense (coin_sense),
        .accept_en  (accept_en),
        .coin       (coin),
        .reject     (reject),
        .jam        (jam),
        .busy       (busy)
    );

    int tests = 0;
    int fails = 0;

    // reference model: raw-sample delay line, run length and dead-time left
    logic       m_q1, m_q2;
    int         m_run, m_deaf;
    logic [1:0] m_coin;
    logic       m_rej;

    int         cyc = 0;
    int         coin_ev, rej_ev, ev_cyc, fall_cyc, rise_cyc, jam_cyc;
    logic [1:0] last_coin;
    logic       prev_jam;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s obs=%0h exp=%0h cyc=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input logic s, input logic a, input logic r);
        coin_sense = s;
        accept_en  = a;
        rst        = r;
        @(posedge clk);
        cyc++;
        m_coin = 2'b00;
        m_rej  = 1'b0;
        if (r) begin
            m_q1 = 0; m_q2 = 0; m_run = 0; m_deaf = 0;
        end else begin
            if (m_deaf > 0) begin
                m_deaf--;
            end else if (m_run > 0) begin
                if (m_q2) begin
                    m_run++;
                end else begin
                    if (m_run < JAM_LIMIT && a &&
                        m_run >= ONE_MIN && m_run <= ONE_MAX)
                        m_coin = 2'b01;
                    else if (m_run < JAM_LIMIT && a &&
                             m_run >= TWO_MIN && m_run <= TWO_MAX)
                        m_coin = 2'b10;
                    else
                        m_rej = 1'b1;
                    m_run  = 0;
                    m_deaf = HOLDOFF;
                end
            end else if (m_q2) begin
                m_run = 1;
            end
            m_q2 = m_q1;
            m_q1 = s;
        end
        #1;
        chk("coin",   32'(coin),   32'(m_coin));
        chk("reject", 32'(reject), 32'(m_rej));
        chk("jam",    32'(jam),    32'(m_run >= JAM_LIMIT));
        chk("busy",   32'(busy),   32'(m_run > 0 || m_deaf > 0));
        chk("excl",   32'(coin != 2'b00 && reject), 32'(0));
        if (coin !== 2'b00) begin
            coin_ev++; last_coin = coin; ev_cyc = cyc;
        end
        if (reject === 1'b1) begin
            rej_ev++; ev_cyc = cyc;
        end
        if (jam === 1'b1 && !prev_jam) jam_cyc = cyc;
        prev_jam = jam;
    endtask

    task automatic clr_ev();
        coin_ev = 0; rej_ev = 0; ev_cyc = -1;
        last_coin = 2'b00; jam_cyc = -1;
    endtask

    task automatic pulse(input int len, input logic acc);
        clr_ev();
        rise_cyc = cyc + 1;
        for (int i = 0; i < len; i++) tick(1'b1, acc, 1'b0);
        fall_cyc = cyc + 1;
        for (int i = 0; i < 14; i++) tick(1'b0, acc, 1'b0);
    endtask

    initial begin
        m_q1 = 0; m_q2 = 0; m_run = 0; m_deaf = 0;
        prev_jam = 1'b0;
        clr_ev();

        for (int i = 0; i < 3; i++) tick(1'(i % 2), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0);

        pulse(5, 1'b1);
        chk("p5_ev",  32'(coin_ev),  32'(1));
        chk("p5_val", 32'(last_coin), 32'(2'b01));
        chk("p5_lat", 32'(ev_cyc - fall_cyc), 32'(2));

        clr_ev();
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'b0);
        fall_cyc = cyc + 1;
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 1'b0);
        chk("p12_ev",  32'(coin_ev),  32'(1));
        chk("p12_val", 32'(last_coin), 32'(2'b10));
        chk("p12_rej", 32'(rej_ev),   32'(0));
        chk("p12_lat", 32'(ev_cyc - fall_cyc), 32'(2));

        pulse(2, 1'b1);
        chk("p2_rej",  32'(rej_ev),  32'(1));
        chk("p2_coin", 32'(coin_ev), 32'(0));
        pulse(9, 1'b1);
        chk("p9_rej",  32'(rej_ev),  32'(1));
        chk("p9_coin", 32'(coin_ev), 32'(0));
        pulse(20, 1'b1);
        chk("p20_rej",  32'(rej_ev),  32'(1));
        chk("p20_coin", 32'(coin_ev), 32'(0));
        pulse(6, 1'b0);
        chk("p6dis_rej",  32'(rej_ev),  32'(1));
        chk("p6dis_coin", 32'(coin_ev), 32'(0));

        pulse(250, 1'b1);
        chk("jam_rise", 32'(jam_cyc - rise_cyc), 32'(201));
        chk("jam_rej",  32'(rej_ev),  32'(1));
        chk("jam_coin", 32'(coin_ev), 32'(0));
        chk("jam_lat",  32'(ev_cyc - fall_cyc), 32'(2));

        clr_ev();
        for (int i = 0; i < 12; i++) tick(1'b1, 1'b1, 1'(i >= 5 && i < 9));
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 1'b0);
        chk("rstmid_coin", 32'(coin_ev), 32'(0));
        chk("rstmid_rej",  32'(rej_ev),  32'(1));

        for (int p = 0; p < 40; p++) begin
            int len, gap;
            len = $urandom_range(1, 20);
            gap = $urandom_range(0, 12);
            for (int i = 0; i < len; i++)
                tick(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            for (int i = 0; i < gap; i++)
                tick(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
